// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: state encodings and default bus widths.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Winner selection for two requesters.
// MEM_ARBITER_ROUND_ROBIN_EN: ties go to the master that did not win last;
// otherwise m0 always wins a tie.
module arb_select (
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    output logic winner
);

    // A sole requester wins; a tie is resolved by the configured policy.
    always_comb begin
        winner = ~req0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        if (req0 && req1) begin
            winner = ~last_winner;
        end
`else
        if (req0 && req1) begin
            winner = 1'b0;
        end
`endif
    end

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
    // Fixed priority has no history; the input is kept for a uniform interface.
    logic unused_last_winner;
    assign unused_last_winner = last_winner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory arbiter (m0 = CPU, m1 = second requester).
// Optional feature macro: MEM_ARBITER_ROUND_ROBIN_EN (round-robin on ties,
// default is fixed priority to m0).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  resn,

    input  logic                  m0_valid,
    input  logic                  m0_instr,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic                  m0_ready,
    output logic [DATA_W-1:0]     m0_rdata,

    input  logic                  m1_valid,
    input  logic                  m1_instr,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_ready,
    output logic [DATA_W-1:0]     m1_rdata,

    output logic                  s_valid,
    output logic                  s_instr,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_ready,
    input  logic [DATA_W-1:0]     s_rdata,

    output logic [1:0]            grant
);

    arb_state_e state_q, state_d;
    logic       winner_c;
    logic       last_winner_c;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_winner_q, last_winner_d;

    // Last-winner history; reset favours m0 on the first tie.
    always_ff @(posedge clk) begin
        if (!resn) begin
            last_winner_q <= 1'b1;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end

    assign last_winner_c = last_winner_q;
`else
    assign last_winner_c = 1'b1;
`endif

    arb_select u_arb_select (
        .req0        (m0_valid),
        .req1        (m1_valid),
        .last_winner (last_winner_c),
        .winner      (winner_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, slave-side mux and completion routing; everything is masked while in reset.
    always_comb begin
        state_d  = state_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_winner_d = last_winner_q;
`endif
        s_valid  = 1'b0;
        s_instr  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        grant    = 2'b00;

        if (resn) begin
            case (state_q)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state_d = winner_c ? GNT1 : GNT0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        last_winner_d = winner_c;
`endif
                    end
                end
                GNT0: begin
                    grant   = 2'b01;
                    s_valid = m0_valid;
                    s_instr = m0_instr;
                    s_addr  = m0_addr;
                    s_wdata = m0_wdata;
                    s_wstrb = m0_wstrb;
                    if (!m0_valid) begin
                        state_d = IDLE;
                    end else if (s_ready) begin
                        m0_ready = 1'b1;
                        m0_rdata = s_rdata;
                        state_d  = IDLE;
                    end
                end
                GNT1: begin
                    grant   = 2'b10;
                    s_valid = m1_valid;
                    s_instr = m1_instr;
                    s_addr  = m1_addr;
                    s_wdata = m1_wdata;
                    s_wstrb = m1_wstrb;
                    if (!m1_valid) begin
                        state_d = IDLE;
                    end else if (s_ready) begin
                        m1_ready = 1'b1;
                        m1_rdata = s_rdata;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a transaction-level owner/last-winner model.
module tb_mem_arbiter;

    logic        clk;
    logic        resn;
    logic [1:0]  mv;
    logic [1:0]  mi;
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];
    logic        m_ready [2];
    logic [31:0] m_rdata [2];
    logic        s_valid;
    logic        s_instr;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 idle, 0, 1) and last tie winner.
    int own  = -1;
    int last = 1;

    // Outputs observed at the most recent check point.
    logic [1:0]  g_obs;
    logic        r_obs [2];
    logic [31:0] rd_obs [2];
    logic [31:0] sa_obs, sw_obs;
    logic [3:0]  ss_obs;
    logic        sv_obs;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_arbiter dut (
        .clk      (clk),
        .resn     (resn),
        .m0_valid (mv[0]),
        .m0_instr (mi[0]),
        .m0_addr  (ma[0]),
        .m0_wdata (mw[0]),
        .m0_wstrb (ms[0]),
        .m0_ready (m_ready[0]),
        .m0_rdata (m_rdata[0]),
        .m1_valid (mv[1]),
        .m1_instr (mi[1]),
        .m1_addr  (ma[1]),
        .m1_wdata (mw[1]),
        .m1_wstrb (ms[1]),
        .m1_ready (m_ready[1]),
        .m1_rdata (m_rdata[1]),
        .s_valid  (s_valid),
        .s_instr  (s_instr),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .grant    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        logic [1:0]  eg;
        logic        esv, esi;
        logic [31:0] esa, esw;
        logic [3:0]  ess;
        logic        er [2];
        logic [31:0] erd [2];
        int          w;
        @(negedge clk);
        eg = 2'b00; esv = 1'b0; esi = 1'b0; esa = '0; esw = '0; ess = '0;
        er[0] = 1'b0; er[1] = 1'b0; erd[0] = '0; erd[1] = '0;
        if (resn && own >= 0) begin
            eg[own] = 1'b1;
            esv = mv[own]; esi = mi[own]; esa = ma[own]; esw = mw[own]; ess = ms[own];
            if (mv[own] && s_ready) begin
                er[own]  = 1'b1;
                erd[own] = s_rdata;
            end
        end
        g_obs = grant; sv_obs = s_valid; sa_obs = s_addr; sw_obs = s_wdata; ss_obs = s_wstrb;
        for (int k = 0; k < 2; k++) begin
            r_obs[k]  = m_ready[k];
            rd_obs[k] = m_rdata[k];
        end
        chk("grant", 64'(grant), 64'(eg));
        chk("s_valid", 64'(s_valid), 64'(esv));
        chk("s_instr", 64'(s_instr), 64'(esi));
        chk("s_addr", 64'(s_addr), 64'(esa));
        chk("s_wdata", 64'(s_wdata), 64'(esw));
        chk("s_wstrb", 64'(s_wstrb), 64'(ess));
        chk("m0_ready", 64'(m_ready[0]), 64'(er[0]));
        chk("m1_ready", 64'(m_ready[1]), 64'(er[1]));
        chk("m0_rdata", 64'(m_rdata[0]), 64'(erd[0]));
        chk("m1_rdata", 64'(m_rdata[1]), 64'(erd[1]));
        if (!resn) begin
            own  = -1;
            last = 1;
        end else if (own < 0) begin
            if (mv != 2'b00) begin
                if (mv == 2'b01)      w = 0;
                else if (mv == 2'b10) w = 1;
                else                  w = RR ? 1 - last : 0;
                own  = w;
                last = w;
            end
        end else if (!mv[own] || s_ready) begin
            own = -1;
        end
        @(posedge clk);
        #1;
    endtask

    logic [1:0] gseq [8];

    initial begin
        resn = 1'b0; mv = 2'b00; mi = 2'b00; s_ready = 1'b0; s_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            ma[k] = '0; mw[k] = '0; ms[k] = '0;
        end

        // Reset held two cycles with m0 requesting; grant in the 2nd cycle after release.
        mv = 2'b01; ma[0] = 32'h0000_0200;
        cycle(); chk("rst_grant0", 64'(g_obs), 64'(2'b00)); chk("rst_sv0", 64'(sv_obs), 64'(1'b0));
        cycle(); chk("rst_grant1", 64'(g_obs), 64'(2'b00)); chk("rst_sv1", 64'(sv_obs), 64'(1'b0));
        resn = 1'b1;
        cycle(); chk("post_rst_idle", 64'(g_obs), 64'(2'b00));
        cycle(); chk("post_rst_gnt0", 64'(g_obs), 64'(2'b01));
        s_ready = 1'b1; s_rdata = 32'h1111_2222;
        cycle(); chk("post_rst_m0_ready", 64'(r_obs[0]), 64'(1'b1));
        mv = 2'b00; s_ready = 1'b0;
        cycle();

        // Solo read by m1, memory answers on the 2nd GNT1 cycle.
        mv = 2'b10; ma[1] = 32'h0000_0100; mi[1] = 1'b0;
        cycle(); chk("solo_idle", 64'(g_obs), 64'(2'b00));
        cycle(); chk("solo_gnt1", 64'(g_obs), 64'(2'b10));
        s_ready = 1'b1; s_rdata = 32'hCAFE_BABE;
        cycle();
        chk("solo_m1_ready", 64'(r_obs[1]), 64'(1'b1));
        chk("solo_m1_rdata", 64'(rd_obs[1]), 64'(32'hCAFE_BABE));
        chk("solo_m0_ready", 64'(r_obs[0]), 64'(1'b0));
        mv = 2'b00; s_ready = 1'b0;
        cycle(); chk("solo_m1_ready_drop", 64'(r_obs[1]), 64'(1'b0));

        // Write pass-through from m0.
        mv = 2'b01; ma[0] = 32'h0000_0040; mw[0] = 32'h1234_5678; ms[0] = 4'b0011;
        cycle();
        cycle();
        chk("wr_s_addr", 64'(sa_obs), 64'(32'h0000_0040));
        chk("wr_s_wdata", 64'(sw_obs), 64'(32'h1234_5678));
        chk("wr_s_wstrb", 64'(ss_obs), 64'(4'b0011));
        s_ready = 1'b1;
        cycle(); chk("wr_m0_ready", 64'(r_obs[0]), 64'(1'b1));
        mv = 2'b00; s_ready = 1'b0; ms[0] = '0;
        cycle();

        // Contention: both request continuously; reset first so history is known.
        resn = 1'b0;
        cycle();
        resn = 1'b1; mv = 2'b11; s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        for (int i = 0; i < 8; i++) begin
            cycle();
            gseq[i] = g_obs;
        end
        for (int i = 0; i < 8; i++) begin
            logic [1:0] eg;
            if (i % 2 == 0)          eg = 2'b00;
            else if (RR && i % 4 == 3) eg = 2'b10;
            else                     eg = 2'b01;
            chk($sformatf("cont_grant_%0d", i), 64'(gseq[i]), 64'(eg));
        end
        mv = 2'b10;
        cycle(); chk("cont_m1_idle", 64'(g_obs), 64'(2'b00));
        cycle(); chk("cont_m1_gnt", 64'(g_obs), 64'(2'b10));
        mv = 2'b00; s_ready = 1'b0;
        cycle();

        // Reset while granted to m1 with s_ready in the same cycle.
        mv = 2'b10;
        cycle();
        cycle(); chk("midrst_gnt1", 64'(g_obs), 64'(2'b10));
        resn = 1'b0; s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("midrst_m1_ready", 64'(r_obs[1]), 64'(1'b0));
        chk("midrst_grant", 64'(g_obs), 64'(2'b00));
        resn = 1'b1; s_ready = 1'b0;
        cycle(); chk("midrst_idle_after", 64'(g_obs), 64'(2'b00));
        mv = 2'b00;
        cycle();

        // Random traffic, including early drops and occasional resets.
        for (int n = 0; n < 400; n++) begin
            resn = ($urandom_range(0, 31) != 0);
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 3) == 0) mv[k] = ~mv[k];
                mi[k] = 1'($urandom_range(0, 1));
                ma[k] = $urandom;
                mw[k] = $urandom;
                ms[k] = 4'($urandom_range(0, 15));
            end
            s_ready = ($urandom_range(0, 2) == 0);
            s_rdata = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
